// File: rtl/gshare_counter_table.sv
// gshare direction predictor: a table of saturating counters indexed by
// the fetch PC, optionally XOR-hashed with a non-speculative global history.
module gshare_counter_table #(
   parameter int IDX_W    = 12,
   parameter int CTR_W    = 2,
   parameter int HIST_W   = 12,
   parameter bit HASH_EN  = 1'b1,
   parameter int INIT_VAL = 2**(CTR_W-1)-1
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             Lookup_Valid,
   input  logic [IDX_W-1:0] Lookup_PC,
   output logic             Pred_Valid,
   output logic             Pred_Taken,
   output logic [IDX_W-1:0] Pred_Index,
   input  logic             Update,
   input  logic [IDX_W-1:0] Update_Index,
   input  logic             Is_Taken,
   output logic             Ready
);

   localparam int DEPTH = 1 << IDX_W;
   localparam logic [CTR_W-1:0] CTR_MAX  = '1;
   localparam logic [CTR_W-1:0] CTR_MIN  = '0;
   localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(INIT_VAL);
   localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);

   typedef enum logic {
      S_INIT,
      S_RUN
   } state_e;

   state_e              state_q;
   state_e              state_d;
   logic [IDX_W-1:0]    ptr_q;
   logic [IDX_W-1:0]    ptr_d;
   logic [HIST_W-1:0]   ghr_q;
   logic [HIST_W-1:0]   ghr_d;
   logic                pvalid_q;
   logic                pvalid_d;
   logic                ptaken_q;
   logic                ptaken_d;
   logic [IDX_W-1:0]    pindex_q;
   logic [IDX_W-1:0]    pindex_d;
   logic                ready_q;
   logic                ready_d;

   logic [CTR_W-1:0]    tbl_q [DEPTH];

   logic [IDX_W-1:0]    hist_ext;
   logic [IDX_W-1:0]    lk_idx;
   logic [HIST_W-1:0]   ghr_shift;
   logic [CTR_W-1:0]    upd_old;
   logic [CTR_W-1:0]    upd_new;
   logic [CTR_W-1:0]    rd_ctr;
   logic                in_init;
   logic                run_upd;
   logic                wr_en;
   logic [IDX_W-1:0]    wr_addr;
   logic [CTR_W-1:0]    wr_data;

   assign hist_ext = IDX_W'(ghr_q);

   generate
      if (HASH_EN) begin : g_hash
         assign lk_idx = Lookup_PC ^ hist_ext;
      end else begin : g_nohash
         assign lk_idx = Lookup_PC;
      end
   endgenerate

   generate
      if (HIST_W == 1) begin : g_hist1
         assign ghr_shift = Is_Taken;
      end else begin : g_histn
         assign ghr_shift = {ghr_q[HIST_W-2:0], Is_Taken};
      end
   endgenerate

   assign in_init = (state_q == S_INIT);
   assign run_upd = !in_init && Update;

   // Saturating train of the counter addressed by the resolved branch
   always_comb begin
      upd_old = tbl_q[Update_Index];
      upd_new = upd_old;
      if (Is_Taken) begin
         if (upd_old != CTR_MAX) begin
            upd_new = upd_old + CTR_ONE;
         end
      end else begin
         if (upd_old != CTR_MIN) begin
            upd_new = upd_old - CTR_ONE;
         end
      end
   end

   // Same-cycle update to the looked-up entry is forwarded to the read
   always_comb begin
      rd_ctr = tbl_q[lk_idx];
      if (run_upd && (Update_Index == lk_idx)) begin
         rd_ctr = upd_new;
      end
   end

   // Single write port shared by the init sweep and training
   always_comb begin
      wr_en   = in_init || run_upd;
      wr_addr = Update_Index;
      wr_data = upd_new;
      if (in_init) begin
         wr_addr = ptr_q;
         wr_data = CTR_INIT;
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      ghr_d    = ghr_q;
      pvalid_d = 1'b0;
      ptaken_d = ptaken_q;
      pindex_d = pindex_q;
      ready_d  = ready_q;
      unique case (state_q)
         S_INIT: begin
            ptr_d   = ptr_q + 1'b1;
            ready_d = 1'b0;
            if (ptr_q == '1) begin
               state_d = S_RUN;
               ready_d = 1'b1;
            end
         end
         S_RUN: begin
            pvalid_d = Lookup_Valid;
            if (Lookup_Valid) begin
               ptaken_d = rd_ctr[CTR_W-1];
               pindex_d = lk_idx;
            end
            if (Update) begin
               ghr_d = ghr_shift;
            end
         end
         default: begin
            state_d = S_INIT;
            ptr_d   = '0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q  <= S_INIT;
         ptr_q    <= '0;
         ghr_q    <= '0;
         pvalid_q <= 1'b0;
         ptaken_q <= 1'b0;
         pindex_q <= '0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         ghr_q    <= ghr_d;
         pvalid_q <= pvalid_d;
         ptaken_q <= ptaken_d;
         pindex_q <= pindex_d;
         ready_q  <= ready_d;
      end
   end

   // Table is deliberately not reset; the sweep initialises it
   always_ff @(posedge CLK) begin
      if (RESET && wr_en) begin
         tbl_q[wr_addr] <= wr_data;
      end
   end

   assign Pred_Valid = pvalid_q;
   assign Pred_Taken = ptaken_q;
   assign Pred_Index = pindex_q;
   assign Ready      = ready_q;

endmodule
